// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite initiator driven by a local command/response port.
module axi_lite_cmd_master #(
  parameter int C_M_AXI_LITE_DATA_WIDTH = 32,
  parameter int C_M_AXI_LITE_ADDR_WIDTH = 5,
  parameter int C_CNT_WIDTH = 16
) (
  input  logic                                   m_axi_lite_aclk,
  input  logic                                   m_axi_lite_aresetn,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic                                   cmd_write,
  input  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic                                   rsp_write,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                             rsp_resp,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     m_axi_lite_awaddr,
  output logic [2:0]                             m_axi_lite_awprot,
  output logic                                   m_axi_lite_awvalid,
  input  logic                                   m_axi_lite_awready,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     m_axi_lite_wdata,
  output logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0]   m_axi_lite_wstrb,
  output logic                                   m_axi_lite_wvalid,
  input  logic                                   m_axi_lite_wready,
  input  logic [1:0]                             m_axi_lite_bresp,
  input  logic                                   m_axi_lite_bvalid,
  output logic                                   m_axi_lite_bready,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     m_axi_lite_araddr,
  output logic [2:0]                             m_axi_lite_arprot,
  output logic                                   m_axi_lite_arvalid,
  input  logic                                   m_axi_lite_arready,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     m_axi_lite_rdata,
  input  logic [1:0]                             m_axi_lite_rresp,
  input  logic                                   m_axi_lite_rvalid,
  output logic                                   m_axi_lite_rready,
  output logic [C_CNT_WIDTH-1:0]                 wr_count,
  output logic [C_CNT_WIDTH-1:0]                 rd_count,
  output logic [C_CNT_WIDTH-1:0]                 err_count
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
  state_t state, state_d;
  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_LITE_DATA_WIDTH-1:0] wdata_q;
  logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0] wstrb_q;
  logic accept, aw_done, w_done, b_cap, r_cap, done;
  logic awvalid_d, wvalid_d, rsp_write_d;
  logic [C_M_AXI_LITE_DATA_WIDTH-1:0] rsp_rdata_d;
  logic [1:0] rsp_resp_d;
  logic [C_CNT_WIDTH-1:0] wr_count_d, rd_count_d, err_count_d;
  assign cmd_ready = state == IDLE;
  assign m_axi_lite_awaddr = addr_q;
  assign m_axi_lite_araddr = addr_q;
  assign m_axi_lite_wdata = wdata_q;
  assign m_axi_lite_wstrb = wstrb_q;
  assign m_axi_lite_awprot = 3'b000;
  assign m_axi_lite_arprot = 3'b000;
  // AW and W retire independently; a channel counts as done once its valid has dropped
  assign aw_done = !m_axi_lite_awvalid || m_axi_lite_awready;
  assign w_done = !m_axi_lite_wvalid || m_axi_lite_wready;
  always_ff @(posedge m_axi_lite_aclk or negedge m_axi_lite_aresetn) begin
    if (!m_axi_lite_aresetn) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      m_axi_lite_awvalid <= 1'b0;
      m_axi_lite_wvalid <= 1'b0;
      m_axi_lite_arvalid <= 1'b0;
      m_axi_lite_bready <= 1'b0;
      m_axi_lite_rready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= 2'b00;
      wr_count <= '0;
      rd_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_q <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
      m_axi_lite_awvalid <= awvalid_d;
      m_axi_lite_wvalid <= wvalid_d;
      m_axi_lite_arvalid <= state_d == RD_REQ;
      m_axi_lite_bready <= state_d == WR_RESP;
      m_axi_lite_rready <= state_d == RD_DATA;
      rsp_valid <= state_d == RSP;
      rsp_write <= rsp_write_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp <= rsp_resp_d;
      wr_count <= wr_count_d;
      rd_count <= rd_count_d;
      err_count <= err_count_d;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_valid) state_d = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) state_d = WR_RESP;
      WR_RESP: if (m_axi_lite_bvalid) state_d = RSP;
      RD_REQ:  if (m_axi_lite_arready) state_d = RD_DATA;
      RD_DATA: if (m_axi_lite_rvalid) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    accept = state == IDLE && cmd_valid;
    b_cap = state == WR_RESP && m_axi_lite_bvalid;
    r_cap = state == RD_DATA && m_axi_lite_rvalid;
    done = state == RSP && rsp_ready;
    awvalid_d = accept ? cmd_write : state == WR_REQ && m_axi_lite_awvalid && !m_axi_lite_awready;
    wvalid_d = accept ? cmd_write : state == WR_REQ && m_axi_lite_wvalid && !m_axi_lite_wready;
    rsp_write_d = b_cap ? 1'b1 : r_cap ? 1'b0 : rsp_write;
    rsp_rdata_d = b_cap ? '0 : r_cap ? m_axi_lite_rdata : rsp_rdata;
    rsp_resp_d = b_cap ? m_axi_lite_bresp : r_cap ? m_axi_lite_rresp : rsp_resp;
    // counters saturate rather than wrap
    wr_count_d = done && rsp_write && !(&wr_count) ? wr_count + C_CNT_WIDTH'(1) : wr_count;
    rd_count_d = done && !rsp_write && !(&rd_count) ? rd_count + C_CNT_WIDTH'(1) : rd_count;
    err_count_d = done && rsp_resp != 2'b00 && !(&err_count) ? err_count + C_CNT_WIDTH'(1) : err_count;
  end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: vector table plus hand sequences against a configurable AXI4-Lite slave model.
module tb_axi_lite_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_write;
  logic [4:0] cmd_addr, awaddr, araddr;
  logic [31:0] cmd_wdata, rsp_rdata, wdata, rdata;
  logic [3:0] cmd_wstrb, wstrb;
  logic [1:0] rsp_resp, bresp, rresp;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [15:0] wr_count, rd_count, err_count;
  axi_lite_cmd_master dut (
    .m_axi_lite_aclk(clk), .m_axi_lite_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
    .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
    .m_axi_lite_araddr(araddr), .m_axi_lite_arprot(arprot), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
    .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );
  // second instance with 2-bit counters for the saturation check; its slave is permanently ready/OKAY
  logic cmd_valid2, cmd_ready2, rsp_valid2, rsp_write2, awvalid2, wvalid2, bready2, arvalid2, rready2;
  logic [31:0] rsp_rdata2, wdata2;
  logic [1:0] rsp_resp2, wr_count2, rd_count2, err_count2;
  logic [4:0] awaddr2, araddr2;
  logic [2:0] awprot2, arprot2;
  logic [3:0] wstrb2;
  axi_lite_cmd_master #(.C_CNT_WIDTH(2)) dut2 (
    .m_axi_lite_aclk(clk), .m_axi_lite_aresetn(rst_n),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(1'b1), .cmd_addr(5'h0C),
    .cmd_wdata(32'h1), .cmd_wstrb(4'hF),
    .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_write(rsp_write2), .rsp_rdata(rsp_rdata2), .rsp_resp(rsp_resp2),
    .m_axi_lite_awaddr(awaddr2), .m_axi_lite_awprot(awprot2), .m_axi_lite_awvalid(awvalid2), .m_axi_lite_awready(1'b1),
    .m_axi_lite_wdata(wdata2), .m_axi_lite_wstrb(wstrb2), .m_axi_lite_wvalid(wvalid2), .m_axi_lite_wready(1'b1),
    .m_axi_lite_bresp(2'b00), .m_axi_lite_bvalid(1'b1), .m_axi_lite_bready(bready2),
    .m_axi_lite_araddr(araddr2), .m_axi_lite_arprot(arprot2), .m_axi_lite_arvalid(arvalid2), .m_axi_lite_arready(1'b1),
    .m_axi_lite_rdata(32'h0), .m_axi_lite_rresp(2'b00), .m_axi_lite_rvalid(1'b1), .m_axi_lite_rready(rready2),
    .wr_count(wr_count2), .rd_count(rd_count2), .err_count(err_count2)
  );
  int aw_lat, w_lat, ar_lat, aw_wait, w_wait, ar_wait;
  logic [1:0] b_resp_cfg, r_resp_cfg;
  logic [31:0] r_data_cfg, s_wdata;
  logic [4:0] s_awaddr, s_araddr;
  logic [3:0] s_wstrb;
  logic aw_got, w_got, aw_hs, w_hs, ar_hs;
  assign awready = awvalid && aw_wait >= aw_lat;
  assign wready = wvalid && w_wait >= w_lat;
  assign arready = arvalid && ar_wait >= ar_lat;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign ar_hs = arvalid && arready;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {aw_wait, w_wait, ar_wait} <= '0;
      {aw_got, w_got, bvalid, rvalid} <= '0;
      {bresp, rresp, rdata} <= '0;
      {s_awaddr, s_araddr, s_wdata, s_wstrb} <= '0;
    end else begin
      aw_wait <= awvalid && !awready ? aw_wait + 1 : 0;
      w_wait <= wvalid && !wready ? w_wait + 1 : 0;
      ar_wait <= arvalid && !arready ? ar_wait + 1 : 0;
      if (aw_hs) s_awaddr <= awaddr;
      if (w_hs) begin
        s_wdata <= wdata;
        s_wstrb <= wstrb;
      end
      if (ar_hs) s_araddr <= araddr;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        bvalid <= 1'b1;
        bresp <= b_resp_cfg;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs) w_got <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata <= r_data_cfg;
        rresp <= r_resp_cfg;
      end
    end
  end
  typedef struct {
    logic w;
    logic [4:0] a;
    logic [31:0] d;
    logic [3:0] s;
    int awl, wl, arl;
    logic [1:0] resp;
    logic [31:0] sdata;
    int hold;
    logic [31:0] exp_rdata;
  } vec_t;
  typedef struct {
    logic w;
    logic [31:0] d;
    logic [1:0] r;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int exp_wr = 0, exp_rd = 0, exp_err = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic [1:0] rr);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    sb.push_back('{w, er, rr});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask
  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: response with no expected entry");
    end else begin
      e = sb.pop_front();
      chk("rsp_write", rsp_write, e.w);
      chk("rsp_rdata", rsp_rdata, e.d);
      chk("rsp_resp", rsp_resp, e.r);
    end
  endtask
  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("rsp_arrive", rsp_valid, 1);
  endtask
  task automatic finish_rsp();
    wait_rsp();
    rsp_ready = 1'b1;
    pop_check();
    @(posedge clk); #1;
    chk("back_idle", cmd_ready, 1);
  endtask
  task automatic run_vec(input vec_t v);
    logic [31:0] d0;
    logic [1:0] r0;
    logic w0;
    aw_lat = v.awl;
    w_lat = v.wl;
    ar_lat = v.arl;
    b_resp_cfg = v.resp;
    r_resp_cfg = v.resp;
    r_data_cfg = v.sdata;
    rsp_ready = v.hold == 0;
    issue(v.w, v.a, v.d, v.s, v.exp_rdata, v.resp);
    if (v.hold > 0) begin
      wait_rsp();
      {d0, r0, w0} = {rsp_rdata, rsp_resp, rsp_write};
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", rsp_valid, 1);
        chk("hold_fields", {rsp_rdata, rsp_resp, rsp_write}, {d0, r0, w0});
        chk("hold_cmd_ready", cmd_ready, 0);
        chk("hold_err_count", err_count, exp_err);
      end
    end
    finish_rsp();
    if (v.w) exp_wr++;
    else exp_rd++;
    if (v.resp != 2'b00) exp_err++;
    chk("wr_count", wr_count, exp_wr);
    chk("rd_count", rd_count, exp_rd);
    chk("err_count", err_count, exp_err);
    if (v.w) chk("slave_write_payload", {s_awaddr, s_wdata, s_wstrb}, {v.a, v.d, v.s});
    else chk("slave_araddr", s_araddr, v.a);
  endtask
  initial begin
    vec_t tv[6];
    int acc, t;
    tv[0] = '{1'b0, 5'h08, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h12345678, 0, 32'h12345678};
    tv[1] = '{1'b1, 5'h1C, 32'hA5A55A5A, 4'h3, 2, 0, 0, 2'b00, 32'h0, 0, 32'h0};
    tv[2] = '{1'b1, 5'h10, 32'h0BADF00D, 4'hC, 0, 0, 0, 2'b10, 32'h0, 5, 32'h0};
    tv[3] = '{1'b0, 5'h14, 32'h0, 4'h0, 0, 0, 3, 2'b11, 32'hCAFEF00D, 2, 32'hCAFEF00D};
    tv[4] = '{1'b0, 5'h00, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'hFFFFFFFF, 0, 32'hFFFFFFFF};
    tv[5] = '{1'b1, 5'h18, 32'h13579BDF, 4'h5, 1, 1, 0, 2'b01, 32'h0, 1, 32'h0};
    {cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, cmd_valid2} = '0;
    {aw_lat, w_lat, ar_lat} = '0;
    {b_resp_cfg, r_resp_cfg, r_data_cfg} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_rsp", {rsp_write, rsp_rdata, rsp_resp}, 0);
    chk("rst_payload", {awaddr, wdata, wstrb}, 0);
    chk("rst_counts", {wr_count, rd_count, err_count}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // minimum-latency write, cycle by cycle
    rsp_ready = 1'b1;
    issue(1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    chk("c1_awwvalid", {awvalid, wvalid}, 2'b11);
    chk("c1_awaddr", awaddr, 5'h04);
    chk("c1_wdata", wdata, 32'hDEADBEEF);
    chk("c1_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("c2_bready", bready, 1);
    @(posedge clk); #1;
    chk("c3_rsp_valid", rsp_valid, 1);
    pop_check();
    @(posedge clk); #1;
    chk("c4_cmd_ready", cmd_ready, 1);
    exp_wr++;
    chk("c4_wr_count", wr_count, exp_wr);
    foreach (tv[i]) run_vec(tv[i]);
    // AW completes three cycles before W
    aw_lat = 0;
    w_lat = 3;
    b_resp_cfg = 2'b00;
    rsp_ready = 1'b1;
    issue(1'b1, 5'h08, 32'h55AA55AA, 4'hF, 32'h0, 2'b00);
    chk("skew_c1_valids", {awvalid, wvalid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("skew_aw_dropped", awvalid, 0);
      chk("skew_w_held", wvalid, 1);
      chk("skew_bready_low", bready, 0);
    end
    @(posedge clk); #1;
    chk("skew_w_dropped", wvalid, 0);
    chk("skew_bready_high", bready, 1);
    finish_rsp();
    exp_wr++;
    chk("skew_wr_count", wr_count, exp_wr);
    // reset while arvalid is waiting on a slow slave
    w_lat = 0;
    ar_lat = 10;
    issue(1'b0, 5'h10, 32'h0, 4'h0, 32'h0, 2'b00);
    chk("mid_arvalid", arvalid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rstmid_arvalid", arvalid, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_counts", {wr_count, rd_count, err_count}, 0);
    sb.delete();
    {exp_wr, exp_rd, exp_err} = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(tv[0]);
    // 2-bit counters must stop at 3 after five writes
    cmd_valid2 = 1'b1;
    acc = 0;
    t = 0;
    while (acc < 5 && t < 200) begin
      @(negedge clk);
      if (cmd_ready2) acc++;
      t++;
    end
    chk("sat_accepts", acc, 5);
    @(posedge clk); #1;
    cmd_valid2 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("sat_wr_count", wr_count2, 2'd3);
    chk("sat_rd_count", rd_count2, 2'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Command-driven AXI4-Lite initiator that turns single-beat read/write requests from a local command port into AXI4-Lite transactions and returns each response on a local response port. It is the bus-master counterpart to the debugger's AXI4-Lite register slave. It drives the slave's register file from on-chip sequencers and from the debug self-test bench. One transaction is outstanding at a time, and every transaction is counted.

## Interface
Parameters:
- C_M_AXI_LITE_DATA_WIDTH, 32: data width; must be 32.
- C_M_AXI_LITE_ADDR_WIDTH, 5: address width.
- C_CNT_WIDTH, 16: width of the statistics counters.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - m_axi_lite_aclk  in  1  clock.
  - m_axi_lite_aresetn  in  1  reset, asynchronous, active-low.
- Command port:
  - cmd_valid  in  1  command present.
  - cmd_ready  out  1  command accepted when both are high.
  - cmd_write  in  1  1 = write, 0 = read.
  - cmd_addr  in  ADDR  byte address.
  - cmd_wdata  in  DATA  write data.
  - cmd_wstrb  in  DATA/8  write strobes.
- Response port:
  - rsp_valid  out  1  response present.
  - rsp_ready  in  1  response consumed when both are high.
  - rsp_write  out  1  echoes cmd_write.
  - rsp_rdata  out  DATA  read data; 0 for writes.
  - rsp_resp  out  2  BRESP or RRESP.
- AXI4-Lite master:
  - m_axi_lite_awaddr/awprot/awvalid/awready
  - m_axi_lite_wdata/wstrb/wvalid/wready
  - m_axi_lite_bresp/bvalid/bready
  - m_axi_lite_araddr/arprot/arvalid/arready
  - m_axi_lite_rdata/rresp/rvalid/rready
  - Widths follow the parameters.
- Statistics:
  - wr_count  out  CNT  completed writes.
  - rd_count  out  CNT  completed reads.
  - err_count  out  CNT  responses with resp != 2'b00.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid the block registers addr, wdata, wstrb and write.
  - write = 1: go to WR_REQ with awvalid = wvalid = 1.
  - write = 0: go to RD_REQ with arvalid = 1.
- WR_REQ:
  - awvalid drops on the cycle after the AW handshake; wvalid drops on the cycle after the W handshake. The two are tracked independently.
  - AW and W may complete in the same cycle or in either order.
  - Once both have completed, go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp, set rsp_rdata = 0 and rsp_write = 1, then go to RSP.
- RD_REQ: arvalid = 1. On arready, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: capture rdata and rresp, set rsp_write = 0, then go to RSP.
- RSP:
  - rsp_valid = 1, with response fields held stable.
  - On rsp_ready, go to IDLE.
  - On exit, increment wr_count or rd_count. Also increment err_count if rsp_resp != 0.
- AXI payload rules:
  - Address, data and strobes stay stable while their valid is high.
  - Valids never deassert before their handshake.
  - awprot = arprot = 3'b000.
- Counters saturate at all-ones and never wrap.
- cmd_ready is low in every state except IDLE. Commands presented while busy are stalled, not dropped.

## Timing
- Reset values:
  - State = IDLE, cmd_ready = 1.
  - rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_resp = 0.
  - awvalid = wvalid = arvalid = bready = rready = 0.
  - Registered address, data and strobe = 0; all counters = 0.
- All outputs are registered except cmd_ready, which is decoded from state.
- Minimum latency, with the slave always ready and responding in the cycle after its handshake:
  - Command accepted at cycle 0.
  - awvalid/arvalid high at cycle 1.
  - bvalid/rvalid observed at cycle 2 at the earliest.
  - rsp_valid high at cycle 3.
  - Back to IDLE at cycle 4 if rsp_ready is held high, so the next command can be accepted at cycle 4.
- Slave backpressure adds cycles one for one; there is no internal timeout.
- Reset asserted mid-transaction: all valids and readies drop immediately, and the block returns to IDLE. Recovery of the slave is the system's responsibility.
- A bvalid or rvalid arriving in a state that does not expect it is ignored; bready and rready stay low.

## Test plan
- Write, slave always ready: cmd addr 0x04, wdata 0xDEADBEEF, wstrb 0xF.
  - Required: awaddr = 0x04 and wdata = 0xDEADBEEF at cycle 1.
  - Required: rsp_valid at cycle 3 with rsp_write = 1, rsp_resp = 0, rsp_rdata = 0; wr_count = 1.
- Read: the slave returns rdata 0x12345678.
  - Required: rsp_rdata = 0x12345678, rsp_write = 0, rd_count = 1.
- Skewed write: awready arrives 3 cycles before wready.
  - Required: awvalid drops after its own handshake while wvalid stays high until wready.
  - Required: bready does not rise until both handshakes are done.
- Error response plus response backpressure: bresp = 2'b10, rsp_ready held low for 5 cycles.
  - Required: rsp fields stay stable and cmd_ready stays low throughout; err_count increments once on the rsp_ready handshake.
- Reset mid-read: aresetn pulsed low while arvalid = 1.
  - Required: arvalid = 0 asynchronously, cmd_ready = 1, all counters = 0.
- Saturation with C_CNT_WIDTH = 2: 5 writes.
  - Required: wr_count = 3.
